// File: rtl/led_latch_receiver.sv
// led_latch_receiver: serial receiver for the LED-driver common shift register.
// Samples SCLK/SIN/LAT through synchronizers, shifts in LATCH_SIZE-bit frames
// MSB-first and decodes each frame on LAT into grayscale or control contents.
// Optional feature macro: LATCH_RX_SOUT_EN adds the SOUT daisy-chain output.
module led_latch_receiver #(
  parameter int LATCH_SIZE = 769,
  parameter int CNT_W      = 10
) (
  input  logic                  CLK_10M,
  input  logic                  nReset,
  input  logic                  SCLK,
  input  logic                  SIN,
  input  logic                  LAT,
  output logic [LATCH_SIZE-2:0] gs_data,
  output logic [335:0]          dc_data,
  output logic [2:0]            mc_r,
  output logic [2:0]            mc_g,
  output logic [2:0]            mc_b,
  output logic [6:0]            bc_r,
  output logic [6:0]            bc_g,
  output logic [6:0]            bc_b,
  output logic [4:0]            fc,
  output logic                  gs_valid,
  output logic                  ctrl_valid,
  output logic                  frame_err,
  output logic                  ctrl_err,
  output logic [CNT_W-1:0]      bit_count
`ifdef LATCH_RX_SOUT_EN
  ,
  output logic                  SOUT
`endif
);

  localparam logic [7:0] CTRL_MAGIC = 8'h96;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  // Bit counter saturates instead of wrapping so oversize frames never alias
  // back to a legal length.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [2:0]            sclk_sync_q, sclk_sync_d;
  logic [1:0]            sin_sync_q,  sin_sync_d;
  logic [2:0]            lat_sync_q,  lat_sync_d;
  logic                  sclk_rise, lat_rise, sin_bit;

  state_t                state_q, state_d;

  logic [LATCH_SIZE-1:0] shift_reg_q, shift_reg_d;
  logic [CNT_W-1:0]      bit_count_q, bit_count_d;

  logic [LATCH_SIZE-2:0] gs_data_q, gs_data_d;
  logic [335:0]          dc_data_q, dc_data_d;
  logic [2:0]            mc_r_q, mc_r_d, mc_g_q, mc_g_d, mc_b_q, mc_b_d;
  logic [6:0]            bc_r_q, bc_r_d, bc_g_q, bc_g_d, bc_b_q, bc_b_d;
  logic [4:0]            fc_q, fc_d;
  logic                  gs_valid_q, gs_valid_d;
  logic                  ctrl_valid_q, ctrl_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  ctrl_err_q, ctrl_err_d;

  // Synchronizer shift chains: two metastability flops plus one delay flop.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    sin_sync_d  = {sin_sync_q[0], SIN};
    lat_sync_d  = {lat_sync_q[1:0], LAT};
  end

  // SIN is tapped at the same depth as SCLK so it reflects the value at the pad edge.
  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign lat_rise  = lat_sync_q[1]  & ~lat_sync_q[2];
  assign sin_bit   = sin_sync_q[1];

  // Synchronizer registers.
  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) begin
      sclk_sync_q <= '0;
      sin_sync_q  <= '0;
      lat_sync_q  <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      sin_sync_q  <= sin_sync_d;
      lat_sync_q  <= lat_sync_d;
    end
  end

  // Frame FSM next state: LAT wins over SCLK so a coincident last bit still decodes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (lat_rise)       state_d = ST_DECODE;
        else if (sclk_rise) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (lat_rise)       state_d = ST_DECODE;
      end
      ST_DECODE:            state_d = ST_IDLE;
      default:              state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Shift/count and decode; a shift in the LAT-detect cycle lands before DECODE reads it.
  always_comb begin
    shift_reg_d  = shift_reg_q;
    bit_count_d  = bit_count_q;
    gs_data_d    = gs_data_q;
    dc_data_d    = dc_data_q;
    mc_r_d       = mc_r_q;
    mc_g_d       = mc_g_q;
    mc_b_d       = mc_b_q;
    bc_r_d       = bc_r_q;
    bc_g_d       = bc_g_q;
    bc_b_d       = bc_b_q;
    fc_d         = fc_q;
    gs_valid_d   = 1'b0;
    ctrl_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    ctrl_err_d   = 1'b0;
    if (state_q == ST_DECODE) begin
      shift_reg_d = '0;
      bit_count_d = '0;
      if (bit_count_q != CNT_W'(LATCH_SIZE)) begin
        frame_err_d = 1'b1;
      end else if (!shift_reg_q[LATCH_SIZE-1]) begin
        gs_data_d  = shift_reg_q[LATCH_SIZE-2:0];
        gs_valid_d = 1'b1;
      end else if (shift_reg_q[767:760] != CTRL_MAGIC) begin
        ctrl_err_d = 1'b1;
      end else begin
        dc_data_d    = shift_reg_q[335:0];
        mc_r_d       = shift_reg_q[338:336];
        mc_g_d       = shift_reg_q[341:339];
        mc_b_d       = shift_reg_q[344:342];
        bc_r_d       = shift_reg_q[351:345];
        bc_g_d       = shift_reg_q[358:352];
        bc_b_d       = shift_reg_q[365:359];
        fc_d         = shift_reg_q[370:366];
        ctrl_valid_d = 1'b1;
      end
    end else if (sclk_rise) begin
      shift_reg_d = {shift_reg_q[LATCH_SIZE-2:0], sin_bit};
      bit_count_d = sat_inc(bit_count_q);
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) begin
      shift_reg_q <= '0;
      bit_count_q <= '0;
    end else begin
      shift_reg_q <= shift_reg_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Decoded output registers and their pulses, updated together.
  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) begin
      gs_data_q    <= '0;
      dc_data_q    <= '0;
      mc_r_q       <= '0;
      mc_g_q       <= '0;
      mc_b_q       <= '0;
      bc_r_q       <= '0;
      bc_g_q       <= '0;
      bc_b_q       <= '0;
      fc_q         <= '0;
      gs_valid_q   <= 1'b0;
      ctrl_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      ctrl_err_q   <= 1'b0;
    end else begin
      gs_data_q    <= gs_data_d;
      dc_data_q    <= dc_data_d;
      mc_r_q       <= mc_r_d;
      mc_g_q       <= mc_g_d;
      mc_b_q       <= mc_b_d;
      bc_r_q       <= bc_r_d;
      bc_g_q       <= bc_g_d;
      bc_b_q       <= bc_b_d;
      fc_q         <= fc_d;
      gs_valid_q   <= gs_valid_d;
      ctrl_valid_q <= ctrl_valid_d;
      frame_err_q  <= frame_err_d;
      ctrl_err_q   <= ctrl_err_d;
    end
  end

  assign gs_data    = gs_data_q;
  assign dc_data    = dc_data_q;
  assign mc_r       = mc_r_q;
  assign mc_g       = mc_g_q;
  assign mc_b       = mc_b_q;
  assign bc_r       = bc_r_q;
  assign bc_g       = bc_g_q;
  assign bc_b       = bc_b_q;
  assign fc         = fc_q;
  assign gs_valid   = gs_valid_q;
  assign ctrl_valid = ctrl_valid_q;
  assign frame_err  = frame_err_q;
  assign ctrl_err   = ctrl_err_q;
  assign bit_count  = bit_count_q;

`ifdef LATCH_RX_SOUT_EN
  logic sclk_fall;
  logic sout_q, sout_d;

  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];

  // Daisy output presents the MSB on the synchronized SCLK falling edge.
  always_comb begin
    sout_d = sout_q;
    if (sclk_fall) sout_d = shift_reg_q[LATCH_SIZE-1];
  end

  // SOUT register.
  always_ff @(posedge CLK_10M or negedge nReset) begin
    if (!nReset) sout_q <= 1'b0;
    else         sout_q <= sout_d;
  end

  assign SOUT = sout_q;
`endif

endmodule
